// File: rtl/wb_ram.sv
// wb_ram: Wishbone classic slave with word-organised RAM, byte-lane writes,
// programmable wait states and error termination for misaligned, out-of-range
// and (optionally) write-protected accesses.
// Optional feature macro: RAM_WRITE_PROTECT_EN. When defined, writes to word
// indices below WP_WORDS are rejected with err and leave memory untouched.
module wb_ram #(
  parameter int unsigned DAT_WIDTH   = 64,
  parameter int unsigned GRANULE     = 8,
  parameter int unsigned ADR_WIDTH   = 16,
  parameter int unsigned DEPTH       = 128,
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned WP_WORDS    = 16,
  parameter string       INIT_FILE   = ""
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           ram_cyc_i,
  input  logic                           ram_stb_i,
  input  logic                           ram_we_i,
  input  logic [ADR_WIDTH-1:0]           ram_adr_i,
  input  logic [DAT_WIDTH/GRANULE-1:0]   ram_sel_i,
  input  logic [DAT_WIDTH-1:0]           ram_dat_i,
  output logic [DAT_WIDTH-1:0]           ram_dat_o,
  output logic                           ram_ack_o,
  output logic                           ram_err_o
);

  localparam int unsigned SEL_WIDTH = DAT_WIDTH / GRANULE;
  localparam int unsigned OFF_W     = $clog2(DAT_WIDTH / 8);
  localparam int unsigned IDX_W     = ADR_WIDTH - OFF_W;
  localparam int unsigned MEM_AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t                 state;
  logic [3:0]             wait_cnt;
  logic                   r_ack;
  logic                   r_err;

  // Request attributes captured in IDLE; WAIT/RESP never look at the bus inputs.
  logic [MEM_AW-1:0]      lat_idx;
  logic                   lat_we;
  logic [SEL_WIDTH-1:0]   lat_sel;
  logic [DAT_WIDTH-1:0]   lat_dat;
  logic                   lat_bad;

  logic [DAT_WIDTH-1:0]   mem [DEPTH];

  logic                   req;
  logic [IDX_W-1:0]       in_idx;
  logic                   in_misaligned;
  logic                   in_range;
  logic                   in_protected;
  logic                   in_bad;

  logic [MEM_AW-1:0]      cur_idx;
  logic                   cur_we;
  logic [SEL_WIDTH-1:0]   cur_sel;
  logic [DAT_WIDTH-1:0]   cur_dat;
  logic                   cur_bad;
  logic                   enter_resp;
  logic                   commit;

  assign req       = ram_cyc_i & ram_stb_i;
  assign ram_ack_o = req & r_ack;
  assign ram_err_o = req & r_err;

  // Classify the incoming request from the live bus inputs.
  always_comb begin
    // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
    in_idx        = ram_adr_i[ADR_WIDTH-1:OFF_W];
    in_misaligned = |ram_adr_i[OFF_W-1:0];
    in_range      = 32'(in_idx) < DEPTH;
`ifdef RAM_WRITE_PROTECT_EN
    in_protected  = ram_we_i && (32'(in_idx) < WP_WORDS);
`else
    // Whole array writable; WP_WORDS has no effect in this build.
    in_protected  = 1'b0 && (32'(in_idx) < WP_WORDS);
`endif
    in_bad        = in_misaligned | ~in_range | in_protected;
  end

  // Pick the request attributes for the transfer completing this cycle: live
  // inputs when jumping straight from IDLE, latched copies when leaving WAIT.
  always_comb begin
    cur_idx    = lat_idx;
    cur_we     = lat_we;
    cur_sel    = lat_sel;
    cur_dat    = lat_dat;
    cur_bad    = lat_bad;
    enter_resp = 1'b0;
    if (state == S_IDLE) begin
      cur_idx = in_idx[MEM_AW-1:0];
      cur_we  = ram_we_i;
      cur_sel = ram_sel_i;
      cur_dat = ram_dat_i;
      cur_bad = in_bad;
    end
    if (!rst_i && req) begin
      if (state == S_IDLE && WAIT_STATES == 0) enter_resp = 1'b1;
      if (state == S_WAIT && wait_cnt == 4'd0) enter_resp = 1'b1;
    end
    commit = enter_resp & cur_we & ~cur_bad;
  end

  // Bus protocol FSM with registered response flags and read data.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst_i) begin
      state     <= S_IDLE;
      wait_cnt  <= 4'd0;
      r_ack     <= 1'b0;
      r_err     <= 1'b0;
      ram_dat_o <= '0;
      lat_idx   <= '0;
      lat_we    <= 1'b0;
      lat_sel   <= '0;
      lat_dat   <= '0;
      lat_bad   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req) begin
            lat_idx <= in_idx[MEM_AW-1:0];
            lat_we  <= ram_we_i;
            lat_sel <= ram_sel_i;
            lat_dat <= ram_dat_i;
            lat_bad <= in_bad;
            if (!enter_resp) begin
              state    <= S_WAIT;
              wait_cnt <= 4'(WAIT_STATES - 1);
            end
          end
        end
        S_WAIT: begin
          if (!req) begin
            state <= S_IDLE;
          end else if (wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        S_RESP: begin
          if (!req) begin
            state <= S_IDLE;
            r_ack <= 1'b0;
            r_err <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase

      if (enter_resp) begin
        state <= S_RESP;
        r_ack <= ~cur_bad;
        r_err <= cur_bad;
        if (!cur_we) ram_dat_o <= cur_bad ? '0 : mem[cur_idx];
      end
    end
  end

  // Byte-lane write port, committed only on a successful entry into RESP.
  always_ff @(posedge clk_i) begin
    // NOTE: the array itself is deliberately not reset; contents survive rst_i.
    if (commit) begin
      for (int unsigned i = 0; i < SEL_WIDTH; i++) begin
        if (cur_sel[i]) mem[cur_idx][i*GRANULE +: GRANULE] <= cur_dat[i*GRANULE +: GRANULE];
      end
    end
  end

endmodule

// File: tb/tb_wb_ram.sv
// tb_wb_ram: self-checking bench for wb_ram. Two instances (0 and 3 wait
// states) are driven with directed and random Wishbone transfers and compared
// against a word/byte array model of the memory contents.
module tb_wb_ram;

`ifdef RAM_WRITE_PROTECT_EN
  localparam bit WP = 1'b1;
`else
  localparam bit WP = 1'b0;
`endif
  localparam int NW = 128;

  logic        clk = 1'b0;
  logic        rst   [2];
  logic        cyc   [2];
  logic        stb   [2];
  logic        we    [2];
  logic [15:0] adr   [2];
  logic [7:0]  sel   [2];
  logic [63:0] wdat  [2];
  logic [63:0] rdat  [2];
  logic        ack   [2];
  logic        err   [2];

  int          checks   = 0;
  int          failures = 0;
  int          ws [2] = '{0, 3};

  logic [63:0] mdl   [2][NW];
  bit          known [2][NW];

  always #5 clk = ~clk;

  wb_ram #(.WAIT_STATES(0)) dut0 (
    .clk_i(clk), .rst_i(rst[0]), .ram_cyc_i(cyc[0]), .ram_stb_i(stb[0]),
    .ram_we_i(we[0]), .ram_adr_i(adr[0]), .ram_sel_i(sel[0]), .ram_dat_i(wdat[0]),
    .ram_dat_o(rdat[0]), .ram_ack_o(ack[0]), .ram_err_o(err[0])
  );

  wb_ram #(.WAIT_STATES(3)) dut3 (
    .clk_i(clk), .rst_i(rst[1]), .ram_cyc_i(cyc[1]), .ram_stb_i(stb[1]),
    .ram_we_i(we[1]), .ram_adr_i(adr[1]), .ram_sel_i(sel[1]), .ram_dat_i(wdat[1]),
    .ram_dat_o(rdat[1]), .ram_ack_o(ack[1]), .ram_err_o(err[1])
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit exp_err(input bit w, input logic [15:0] a);
    int idx;
    idx = int'(a[15:3]);
    return (a[2:0] != 3'd0) || (idx >= NW) || (WP && w && idx < 16);
  endfunction

  // One bus transfer; bus inputs are scrambled after the first edge to show
  // that the slave only uses what it sampled in IDLE.
  task automatic xfer(input int d, input bit w, input logic [15:0] a, input logic [7:0] s,
                      input logic [63:0] wd, output logic o_ack, output logic o_err,
                      output logic [63:0] o_dat, output int lat);
    @(negedge clk);
    cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; adr[d] = a; sel[d] = s; wdat[d] = wd;
    lat = 0;
    while (lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (ack[d] || err[d]) break;
      we[d] = 1'($urandom); adr[d] = 16'($urandom); sel[d] = 8'($urandom);
      wdat[d] = {$urandom, $urandom};
    end
    o_ack = ack[d]; o_err = err[d]; o_dat = rdat[d];
    cyc[d] = 1'b0; stb[d] = 1'b0;
    @(posedge clk); #1;
    check("ack_drop", {63'd0, ack[d]}, 64'd0);
  endtask

  // Transfer plus comparison against the model, then model update.
  task automatic ctx(input int d, input bit w, input logic [15:0] a, input logic [7:0] s,
                     input logic [63:0] wd, input string tag);
    logic        g_ack, g_err;
    logic [63:0] g_dat;
    int          lat;
    bit          e;
    int          idx;
    e   = exp_err(w, a);
    idx = int'(a[15:3]);
    xfer(d, w, a, s, wd, g_ack, g_err, g_dat, lat);
    check({tag, "_ack"}, {63'd0, g_ack}, {63'd0, ~e});
    check({tag, "_err"}, {63'd0, g_err}, {63'd0, e});
    check({tag, "_lat"}, 64'(lat), 64'(1 + ws[d]));
    if (!w) begin
      if (e) check({tag, "_rd0"}, g_dat, 64'd0);
      else if (known[d][idx]) check({tag, "_rd"}, g_dat, mdl[d][idx]);
    end else if (!e) begin
      for (int i = 0; i < 8; i++)
        if (s[i]) mdl[d][idx][i*8 +: 8] = wd[i*8 +: 8];
      if (s == 8'hFF) known[d][idx] = 1'b1;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    logic        g_ack, g_err;
    logic [63:0] g_dat, old_dat;
    int          lat;

    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0;
      adr[d] = '0; sel[d] = '0; wdat[d] = '0;
      for (int i = 0; i < NW; i++) known[d][i] = 1'b0;
    end
    old_dat = '0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check("rst_dat", rdat[d], 64'd0);
      check("rst_ack", {63'd0, ack[d]}, 64'd0);
      check("rst_err", {63'd0, err[d]}, 64'd0);
    end
    @(negedge clk);
    rst[0] = 1'b0; rst[1] = 1'b0;

    // Preload every word with a random full-width value.
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < NW; i++)
        ctx(d, 1'b1, 16'(i * 8), 8'hFF, {$urandom, $urandom}, "pre");

    // Basic write/read, zero wait states.
    ctx(0, 1'b1, 16'h0040, 8'hFF, 64'h1122334455667788, "t1_wr");
    ctx(0, 1'b0, 16'h0040, 8'h00, 64'd0, "t1_rd");
    check("t1_lit", mdl[0][8], 64'h1122334455667788);

    // Byte lanes.
    ctx(0, 1'b1, 16'h0080, 8'hFF, 64'd0, "t2_pre");
    ctx(0, 1'b1, 16'h0080, 8'h0F, 64'hAABBCCDDEEFF0011, "t2_wr");
    ctx(0, 1'b0, 16'h0080, 8'h00, 64'd0, "t2_rd");
    ctx(0, 1'b1, 16'h0088, 8'h00, 64'hFFFF_FFFF_FFFF_FFFF, "t2_sel0");
    ctx(0, 1'b0, 16'h0088, 8'h00, 64'd0, "t2_sel0rd");

    // Error terminations, then a normal read.
    ctx(0, 1'b0, 16'h0403, 8'h00, 64'd0, "t3_mis");
    ctx(0, 1'b0, 16'h0400, 8'h00, 64'd0, "t3_oor");
    ctx(0, 1'b1, 16'h0405, 8'hFF, 64'h5555, "t3_wmis");
    ctx(0, 1'b0, 16'h0080, 8'h00, 64'd0, "t3_ok");

    // Wait states: latency and abort in the second WAIT cycle.
    ctx(1, 1'b0, 16'h0148, 8'h00, 64'd0, "t4_rd");
    @(negedge clk);
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = 16'h0148;
    sel[1] = 8'hFF; wdat[1] = 64'hCAFEF00DCAFEF00D;
    for (int k = 0; k < 3; k++) begin
      if (k == 2) stb[1] = 1'b0;
      @(posedge clk); #1;
      check("t4_abort_ack", {63'd0, ack[1]}, 64'd0);
      check("t4_abort_err", {63'd0, err[1]}, 64'd0);
    end
    cyc[1] = 1'b0;
    @(posedge clk);
    ctx(1, 1'b0, 16'h0148, 8'h00, 64'd0, "t4_after");

    // Write protect region.
    if (WP) begin
      xfer(0, 1'b0, 16'h0008, 8'h00, 64'd0, g_ack, g_err, old_dat, lat);
    end
    ctx(0, 1'b1, 16'h0008, 8'hFF, 64'h000000000000DEAD, "t5_wp");
    ctx(0, 1'b0, 16'h0008, 8'h00, 64'd0, "t5_rd");
    if (WP) begin
      xfer(0, 1'b0, 16'h0008, 8'h00, 64'd0, g_ack, g_err, g_dat, lat);
      check("t5_unchanged", g_dat, old_dat);
    end
    ctx(0, 1'b1, 16'h0080, 8'hFF, 64'h0123456789ABCDEF, "t5_ok");
    ctx(0, 1'b0, 16'h0080, 8'h00, 64'd0, "t5_okrd");

    // Reset during WAIT of a write.
    @(negedge clk);
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = 16'h0140;
    sel[1] = 8'hFF; wdat[1] = 64'hBADBADBADBADBAD0;
    @(posedge clk); #1;
    rst[1] = 1'b1;
    @(posedge clk); #1;
    check("t6_ack", {63'd0, ack[1]}, 64'd0);
    check("t6_err", {63'd0, err[1]}, 64'd0);
    check("t6_dat", rdat[1], 64'd0);
    rst[1] = 1'b0; cyc[1] = 1'b0; stb[1] = 1'b0;
    @(posedge clk);
    ctx(1, 1'b0, 16'h0140, 8'h00, 64'd0, "t6_rd");

    // Random traffic on both instances.
    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 80; n++) begin
        int          idx;
        int          mis;
        logic [15:0] a;
        idx = int'($urandom_range(0, 131));
        mis = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 7)) : 0;
        a   = 16'(idx * 8 + mis);
        ctx(d, 1'($urandom), a, 8'($urandom), {$urandom, $urandom}, "rnd");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
